// File: rtl/matrix_stream_pkg.sv
// matrix_stream_pkg: state encoding and width defaults shared by the matrix stream driver files
package matrix_stream_pkg;
  typedef enum logic [1:0] {IDLE, SEND, COLLECT} state_t;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_C_DATA_WIDTH = 2 * DEFAULT_DATA_WIDTH + 16;
endpackage

// File: rtl/c_stream_collector.sv
// c_stream_collector: counts C beats and steers each row or column beat into the N x N result register
// ports: clear_i zeroes result and counter; en_i marks the collect phase; beat = en_i & valid & ready;
//        c_matrix_o[i][j] is C[i][j]; final_beat_o flags the Nth beat
module c_stream_collector
  import matrix_stream_pkg::*;
#(
  parameter int N = 4,
  parameter int C_DATA_WIDTH = DEFAULT_C_DATA_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  input  logic row_mode_i,
  input  logic output_valid_i,
  input  logic output_ready_i,
  input  logic [N-1:0][C_DATA_WIDTH-1:0] c_stream_i,
  output logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0] c_matrix_o,
  output logic final_beat_o
);
  localparam int RW = $clog2(N + 1);
  logic [RW-1:0] r_q, r_d;
  logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0] c_q, c_d;
  logic beat;
  assign beat = en_i && output_valid_i && output_ready_i;
  assign final_beat_o = beat && r_q == RW'(N - 1);
  assign c_matrix_o = c_q;
  always_comb begin
    r_d = clear_i ? '0 : r_q + RW'(beat);
    c_d = clear_i ? '0 : c_q;
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        if (beat && r_q == RW'(x)) begin
          if (row_mode_i) c_d[x][y] = c_stream_i[y];
          else c_d[y][x] = c_stream_i[y];
        end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end
endmodule

// File: rtl/matrix_stream_driver.sv
// matrix_stream_driver: latches A/B on start, streams K operand beats to the systolic array, collects N C beats
// ports: start/a_matrix/b_matrix/row_mode sampled in IDLE; hold throttles both handshakes;
//        a_*/b_*/last/input_ready form the operand stream; output_*/c_stream form the result stream;
//        busy outside IDLE, done pulses one cycle when c_matrix is complete
module matrix_stream_driver
  import matrix_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N = 4,
  parameter int K = 4,
  parameter int C_DATA_WIDTH = DEFAULT_C_DATA_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [N-1:0][K-1:0][DATA_WIDTH-1:0] a_matrix,
  input  logic [K-1:0][N-1:0][DATA_WIDTH-1:0] b_matrix,
  input  logic row_mode,
  input  logic hold,
  output logic busy,
  output logic done,
  output logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0] c_matrix,
  output logic a_valid,
  output logic b_valid,
  output logic [N-1:0][DATA_WIDTH-1:0] a_data,
  output logic [N-1:0][DATA_WIDTH-1:0] b_data,
  output logic last,
  input  logic input_ready,
  output logic output_ready,
  output logic output_by_row,
  input  logic output_valid,
  input  logic [N-1:0][C_DATA_WIDTH-1:0] c_stream
);
  localparam int KW = $clog2(K + 1);
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0][K-1:0][DATA_WIDTH-1:0] a_q;
  logic [K-1:0][N-1:0][DATA_WIDTH-1:0] b_q;
  logic row_q, done_q, accept, send, xfer, final_beat;
  assign accept = state_q == IDLE && start;
  assign send = state_q == SEND;
  // valid ignores input_ready: the array's ready is a function of valid
  assign a_valid = send && !hold;
  assign b_valid = a_valid;
  assign xfer = a_valid && input_ready;
  assign last = send && k_q == KW'(K - 1);
  assign output_ready = state_q == COLLECT && !hold;
  assign output_by_row = row_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  always_comb begin
    a_data = '0;
    b_data = '0;
    for (int x = 0; x < K; x++)
      if (send && k_q == KW'(x)) begin
        for (int i = 0; i < N; i++) a_data[i] = a_q[i][x];
        b_data = b_q[x];
      end
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        k_d = '0;
      end
      SEND: begin
        k_d = k_q + KW'(xfer);
        state_d = xfer && last ? COLLECT : SEND;
      end
      COLLECT: state_d = final_beat ? IDLE : COLLECT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      row_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      done_q <= final_beat;
      if (accept) begin
        a_q <= a_matrix;
        b_q <= b_matrix;
        row_q <= row_mode;
      end
    end
  end
  c_stream_collector #(.N(N), .C_DATA_WIDTH(C_DATA_WIDTH)) u_collect (
    .clk(clk),
    .reset(reset),
    .clear_i(accept),
    .en_i(state_q == COLLECT),
    .row_mode_i(row_q),
    .output_valid_i(output_valid),
    .output_ready_i(output_ready),
    .c_stream_i(c_stream),
    .c_matrix_o(c_matrix),
    .final_beat_o(final_beat)
  );
endmodule

// File: doc/matrix_stream_driver.md
# matrix_stream_driver

Initiator for the sum-stationary systolic array. It latches a full A (N×K) and B (K×N) operand pair on `start`. It streams A column-by-column and B row-by-row into the array's valid/ready input port, asserting `last` on the final beat. It then drains the N-beat C stream, row-wise or column-wise, into an N×N result register and pulses `done`. It sits between the host/test controller and the array, and is the array's only source and sink.

## Interface
- `DATA_WIDTH`, 8, operand width (unsigned)
- `N`, 4, array side length; rows of A, columns of B, C is N×N
- `K`, 4, inner dimension = number of streamed beats; K ≥ 1
- `C_DATA_WIDTH`, 32, width of one C element (array multiply + accumulate width)
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request; accepted only in IDLE
- `a_matrix`  in  [DATA_WIDTH] [N][K]  A operand; sampled on accepted `start`
- `b_matrix`  in  [DATA_WIDTH] [K][N]  B operand; sampled on accepted `start`
- `row_mode`  in  1  1 = collect C by rows, 0 = by columns; sampled on accepted `start`
- `hold`  in  1  throttle; while high, `a_valid`/`b_valid`/`output_ready` are forced low
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when C is complete
- `c_matrix`  out  [C_DATA_WIDTH] [N][N]  collected result; stable after `done` until next accepted `start`
- `a_valid`, `b_valid`  out  1  to array; always driven identically
- `a_data`  out  [DATA_WIDTH] [N]  `a_data[i]` = A[i][k]
- `b_data`  out  [DATA_WIDTH] [N]  `b_data[j]` = B[k][j]
- `last`  out  1  high with beat k = K-1 only
- `input_ready`  in  1  from array; may combinationally depend on valid
- `output_ready`  out  1  to array
- `output_by_row`  out  1  to array; latched `row_mode`, constant for the whole job
- `output_valid`  in  1  from array
- `c_stream`  in  [C_DATA_WIDTH] [N]  from array, one row or column per beat

## Operation
- States: IDLE, SEND, COLLECT.
- IDLE → SEND on `start`. Latch A, B, `row_mode`; clear `c_matrix` to 0; set k = 0 and r = 0.
- SEND:
  - `a_valid` = `b_valid` = !`hold`; data = column/row k; `last` = (k == K-1).
  - Valid never waits on `input_ready`, because the array's ready depends on valid.
  - Transfer = `a_valid` && `input_ready`; k increments per transfer.
  - A transfer with `last` → COLLECT.
- COLLECT:
  - `output_ready` = !`hold`; beat = `output_valid` && `output_ready`.
  - `row_mode`=1: C[r][j] ← `c_stream[j]`. `row_mode`=0: C[i][r] ← `c_stream[i]`. r increments per beat.
  - Beat with r == N-1 → IDLE and `done`=1 the next cycle.
- Outside SEND: valid, data, and `last` are 0. Outside COLLECT: `output_ready`=0.
- Counters: k is $clog2(K+1) bits and r is $clog2(N+1) bits; neither wraps within a job.
- `start` while busy is ignored; no queueing.
- `hold` changes take effect the same cycle. Job state is not lost.
- All arithmetic lives in the array. This block only moves data.

## Timing
- Reset values: state IDLE; all outputs 0, including `c_matrix`, `done`, and `busy`.
- First valid beat appears the cycle after `start`. With no `hold` and the array always ready, the send phase is exactly K cycles.
- COLLECT begins the cycle after the last transfer. The array's compute latency is absorbed by waiting on `output_valid`.
- After the Nth C beat, `done` is registered high for 1 cycle and `busy` falls in that same cycle. A new `start` is legal in that cycle.
- Reset mid-job returns to IDLE next cycle with outputs zeroed. The array must share the same reset.

## Structure
- Package `matrix_stream_pkg`: the state enum typedef and a default C width constant (2·DATA_WIDTH + 16).
- One sub-module, `c_stream_collector`: beat counter r, row/column write steering into the N×N register, and the final-beat flag.
- The FSM, the operand latches, and the k counter live in the top-level module.

## Test plan
- A = identity, B[k][j] = 4k+j+1, `row_mode`=1, array always ready → 4 beats with `last` on the 4th; `c_matrix` = B; one `done` pulse.
- Same operands with `row_mode`=0 → `output_by_row`=0 held throughout; `c_matrix` still equals B, transposed beats steered correctly.
- A = all 2, B = all 3, `hold` toggled every other cycle through SEND and COLLECT → no beat lost or duplicated; every C element = 24.
- K=1, A[i][0] = i+1, B[0][j] = j+1 → a single beat carries `last`; C[i][j] = (i+1)(j+1).
- `start` pulsed again during SEND → ignored; the result matches the first operands only.
- Reset asserted during COLLECT → next cycle all outputs are 0 and state is IDLE; a fresh job then completes correctly.
